// File: rtl/sram_controller_if.sv
// Wishbone-classic style request/response bundle between the CPU memory port
// and one sram_controller instance.
interface sram_controller_if;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        input  wb_ack_o, wb_dat_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
        output wb_ack_o, wb_dat_o
    );
endinterface

// File: rtl/sram_controller.sv
// Bridge from single Wishbone accesses to one asynchronous 32-bit SRAM bank,
// with fixed setup/pulse/hold sequencing and fully registered SRAM pins.
module sram_controller #(
    parameter int ADDR_WIDTH   = 20,
    parameter int READ_CYCLES  = 2,
    parameter int WRITE_CYCLES = 1
) (
    input  logic                  clk_50M,
    input  logic                  reset_btn,
    sram_controller_if.slave      wb,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    inout  wire  [31:0]           ram_data,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    output logic [3:0]            ram_be_n
);

    localparam int MAX_CYCLES = (READ_CYCLES > WRITE_CYCLES) ? READ_CYCLES : WRITE_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] READ_LAST  = CNT_W'(READ_CYCLES - 1);
    localparam logic [CNT_W-1:0] WRITE_LAST = CNT_W'(WRITE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_READ     = 3'd1,
        ST_WR_SETUP = 3'd2,
        ST_WR_PULSE = 3'd3,
        ST_WR_HOLD  = 3'd4,
        ST_DONE     = 3'd5
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [31:0]             wdat_q, wdat_d;
    logic [3:0]              sel_q, sel_d;
    logic [31:0]             rdat_q, rdat_d;
    logic                    ce_n_q, ce_n_d;
    logic                    oe_n_q, oe_n_d;
    logic                    we_n_q, we_n_d;
    logic [3:0]              be_n_q, be_n_d;
    logic                    drive_q, drive_d;
    logic                    ack_q, ack_d;
    logic                    req_s;
    logic                    unused_adr_s;

    assign req_s        = wb.wb_cyc_i & wb.wb_stb_i;
    assign unused_adr_s = ^{wb.wb_adr_i[31:ADDR_WIDTH+2], wb.wb_adr_i[1:0]};

    // Next-state sequencing plus request capture and read-data latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        rdat_d  = rdat_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s) begin
                    addr_d  = wb.wb_adr_i[ADDR_WIDTH+1:2];
                    wdat_d  = wb.wb_dat_i;
                    sel_d   = wb.wb_sel_i;
                    cnt_d   = '0;
                    state_d = wb.wb_we_i ? ST_WR_SETUP : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_READ: begin
                if (cnt_q == READ_LAST) begin
                    rdat_d  = ram_data;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_SETUP: begin
                cnt_d   = '0;
                state_d = ST_WR_PULSE;
            end
            ST_WR_PULSE: begin
                if (cnt_q == WRITE_LAST) begin
                    state_d = ST_WR_HOLD;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WR_HOLD: begin
                state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Pin values are decoded from the upcoming state so they register on the same edge.
    always_comb begin
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        be_n_d  = 4'hF;
        drive_d = 1'b0;
        ack_d   = 1'b0;
        case (state_d)
            ST_READ: begin
                ce_n_d = 1'b0;
                oe_n_d = 1'b0;
                be_n_d = ~sel_d;
            end
            ST_WR_SETUP, ST_WR_HOLD: begin
                ce_n_d  = 1'b0;
                be_n_d  = ~sel_d;
                drive_d = 1'b1;
            end
            ST_WR_PULSE: begin
                ce_n_d  = 1'b0;
                we_n_d  = 1'b0;
                be_n_d  = ~sel_d;
                drive_d = 1'b1;
            end
            ST_DONE: begin
                ack_d = 1'b1;
            end
            default: begin
                ack_d = 1'b0;
            end
        endcase
    end

    // State, captured request and registered SRAM/bus outputs.
    always_ff @(posedge clk_50M) begin
        if (reset_btn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdat_q  <= 32'h0000_0000;
            sel_q   <= 4'h0;
            rdat_q  <= 32'h0000_0000;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            be_n_q  <= 4'hF;
            drive_q <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            rdat_q  <= rdat_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            be_n_q  <= be_n_d;
            drive_q <= drive_d;
            ack_q   <= ack_d;
        end
    end

    // Bus is only driven in write states, where OE is never asserted.
    assign ram_data    = drive_q ? wdat_q : 32'bz;
    assign ram_addr    = addr_q;
    assign ram_ce_n    = ce_n_q;
    assign ram_oe_n    = oe_n_q;
    assign ram_we_n    = we_n_q;
    assign ram_be_n    = be_n_q;
    assign wb.wb_ack_o = ack_q;
    assign wb.wb_dat_o = rdat_q;

endmodule

// File: tb/tb_sram_controller.sv
// Scoreboard bench for sram_controller: directed accesses against a small SRAM model.
module tb_sram_controller;

    typedef struct {
        logic        is_read;
        logic [31:0] wdat;
        logic [31:0] exp_dat;
        logic [19:0] exp_addr;
        logic [3:0]  exp_be_n;
        int          exp_cyc;
    } entry_t;

    logic        clk_50M = 1'b0;
    logic        reset_btn = 1'b1;
    logic [19:0] ram_addr;
    wire  [31:0] ram_data;
    logic        ram_ce_n, ram_oe_n, ram_we_n;
    logic [3:0]  ram_be_n;

    int     checks = 0;
    int     errors = 0;
    int     cycle_cnt = 0;
    entry_t sbq[$];
    logic [31:0] mem [64];

    sram_controller_if bus();

    sram_controller dut (
        .clk_50M  (clk_50M),
        .reset_btn(reset_btn),
        .wb       (bus),
        .ram_addr (ram_addr),
        .ram_data (ram_data),
        .ram_ce_n (ram_ce_n),
        .ram_oe_n (ram_oe_n),
        .ram_we_n (ram_we_n),
        .ram_be_n (ram_be_n)
    );

    initial forever #10 clk_50M = ~clk_50M;

    always @(posedge clk_50M) cycle_cnt <= cycle_cnt + 1;

    assign ram_data = (!ram_ce_n && !ram_oe_n && ram_we_n) ? mem[ram_addr[5:0]] : 32'bz;

    // SRAM model: preload, then commit enabled byte lanes while WE is low.
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h0000_0000;
        mem[0] = 32'hAABB_CCDD;
        mem[2] = 32'h2222_2222;
        mem[5] = 32'h1234_5678;
        forever begin
            @(negedge clk_50M);
            if (!ram_ce_n && !ram_we_n) begin
                for (int b = 0; b < 4; b++)
                    if (!ram_be_n[b]) mem[ram_addr[5:0]][8*b +: 8] = ram_data[8*b +: 8];
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        checks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    task automatic start_req(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                             input logic [3:0] sel, input logic [31:0] exp_dat,
                             input logic [19:0] exp_addr, input int exp_cyc);
        entry_t e;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = we;
        bus.wb_adr_i = adr;
        bus.wb_dat_i = dat;
        bus.wb_sel_i = sel;
        e.is_read  = !we;
        e.wdat     = dat;
        e.exp_dat  = exp_dat;
        e.exp_addr = exp_addr;
        e.exp_be_n = ~sel;
        e.exp_cyc  = exp_cyc;
        sbq.push_back(e);
    endtask

    task automatic wait_ack();
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_50M);
            if (bus.wb_ack_o) return;
        end
        flag("ack_timeout");
    endtask

    task automatic drop_req();
        bus.wb_cyc_i = 1'b0;
        bus.wb_stb_i = 1'b0;
    endtask

    // One isolated access: read ack three cycles after issue, write ack four.
    task automatic single(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                          input logic [3:0] sel, input logic [31:0] exp_dat,
                          input logic [19:0] exp_addr);
        @(posedge clk_50M); #1;
        start_req(we, adr, dat, sel, exp_dat, exp_addr, cycle_cnt + (we ? 4 : 3));
        wait_ack();
        @(posedge clk_50M); #1;
        drop_req();
    endtask

    // Monitor: pops the scoreboard on ack and checks pin behaviour every cycle.
    initial begin
        entry_t e;
        int     oe_run = 0;
        logic   ack_prev = 1'b0;
        forever begin
            @(negedge clk_50M);
            if (bus.wb_ack_o) begin
                if (sbq.size() == 0) begin
                    flag("unexpected_ack");
                end else begin
                    e = sbq.pop_front();
                    chk("ack_cycle", 32'(cycle_cnt), 32'(e.exp_cyc));
                    chk(e.is_read ? "read_data" : "held_read_data", bus.wb_dat_o, e.exp_dat);
                end
            end
            if (bus.wb_ack_o && ack_prev) flag("ack_wider_than_one_cycle");
            ack_prev = bus.wb_ack_o;
            if (!ram_ce_n && sbq.size() > 0) begin
                chk("ram_addr", {12'h000, ram_addr}, {12'h000, sbq[0].exp_addr});
                chk("ram_be_n", {28'h0, ram_be_n}, {28'h0, sbq[0].exp_be_n});
                if (!ram_we_n) chk("write_data", ram_data, sbq[0].wdat);
            end
            if (!ram_oe_n && !ram_we_n) flag("bus_contention_oe_we");
            if (!ram_oe_n) begin
                oe_run++;
            end else if (oe_run != 0) begin
                chk("oe_low_cycles", 32'(oe_run), 32'd2);
                oe_run = 0;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog_expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1;
        bus.wb_cyc_i = 1'b1;
        bus.wb_stb_i = 1'b1;
        bus.wb_we_i  = 1'b0;
        bus.wb_adr_i = 32'h0000_0014;
        bus.wb_dat_i = 32'h0000_0000;
        bus.wb_sel_i = 4'hF;

        // Reset held two cycles with a request pending.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_50M);
            chk("rst_ack", {31'h0, bus.wb_ack_o}, 32'd0);
            chk("rst_ctrl_n", {29'h0, ram_ce_n, ram_oe_n, ram_we_n}, 32'd7);
            chk("rst_be_n", {28'h0, ram_be_n}, 32'hF);
            chk("rst_dat_o", bus.wb_dat_o, 32'h0);
            chk("rst_addr", {12'h000, ram_addr}, 32'h0);
        end
        @(posedge clk_50M); #1;
        drop_req();
        reset_btn = 1'b0;
        @(negedge clk_50M);
        chk("post_rst_idle_ce_n", {31'h0, ram_ce_n}, 32'd1);

        single(1'b0, 32'h0000_0014, 32'h0, 4'hF, 32'h1234_5678, 20'd5);
        single(1'b1, 32'h0000_0000, 32'h0000_1100, 4'b0010, 32'h1234_5678, 20'd0);
        single(1'b0, 32'h0000_0000, 32'h0, 4'hF, 32'hAABB_11DD, 20'd0);
        single(1'b1, 32'h0000_000C, 32'hFFFF_FFFF, 4'b0000, 32'hAABB_11DD, 20'd3);
        single(1'b0, 32'h0000_000C, 32'h0, 4'hF, 32'h0000_0000, 20'd3);

        // Back-to-back write then read with strobe held; second ack 4 cycles later.
        @(posedge clk_50M); #1;
        c1 = cycle_cnt + 4;
        start_req(1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 20'd16, c1);
        wait_ack();
        @(posedge clk_50M); #1;
        start_req(1'b0, 32'h0000_0040, 32'h0, 4'hF, 32'hDEAD_BEEF, 20'd16, c1 + 4);
        wait_ack();
        @(posedge clk_50M); #1;
        drop_req();

        // Upper address bits ignored.
        single(1'b0, 32'h0040_0008, 32'h0, 4'h1, 32'h2222_2222, 20'd2);

        // Reset during the write pulse aborts without ack.
        @(posedge clk_50M); #1;
        start_req(1'b1, 32'h0000_0020, 32'h5555_5555, 4'hF, 32'h0, 20'd8, 0);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk_50M);
            if (!ram_we_n) break;
        end
        chk("abort_saw_we_low", {31'h0, ram_we_n}, 32'd0);
        reset_btn = 1'b1;
        @(posedge clk_50M); #1;
        sbq.delete();
        @(negedge clk_50M);
        chk("abort_we_n", {31'h0, ram_we_n}, 32'd1);
        chk("abort_ce_n", {31'h0, ram_ce_n}, 32'd1);
        chk("abort_ack", {31'h0, bus.wb_ack_o}, 32'd0);
        @(posedge clk_50M); #1;
        drop_req();
        @(posedge clk_50M); #1;
        reset_btn = 1'b0;
        repeat (3) @(negedge clk_50M);
        chk("abort_no_late_ack", {31'h0, bus.wb_ack_o}, 32'd0);

        single(1'b0, 32'h0000_0014, 32'h0, 4'hF, 32'h1234_5678, 20'd5);

        repeat (5) @(posedge clk_50M);
        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
# sram_controller

Bus-to-SRAM bridge between the CPU's data/instruction memory port and one 1M×32 asynchronous SRAM bank (BaseRAM or ExtRAM); one instance per bank inside `riscv_cpu_top`. It accepts single Wishbone-classic style word or byte-lane accesses, sequences CE/OE/WE and byte enables with fixed setup/pulse/hold cycles, and tri-states the shared data bus when not writing. All SRAM-facing outputs are registered.

## Interface
- `ADDR_WIDTH`, 20, SRAM word-address width
- `READ_CYCLES`, 2, cycles CE/OE held low before data is sampled (≥1)
- `WRITE_CYCLES`, 1, cycles WE held low (≥1)
- `clk_50M`  in  1  system clock; all logic on rising edge
- `reset_btn`  in  1  synchronous, active-high reset
- `wb_cyc_i`  in  1  bus cycle active
- `wb_stb_i`  in  1  request strobe
- `wb_we_i`  in  1  1 = write, 0 = read
- `wb_adr_i`  in  32  byte address; `ram_addr` = `wb_adr_i[ADDR_WIDTH+1:2]`, other bits ignored
- `wb_dat_i`  in  32  write data
- `wb_sel_i`  in  4  byte-lane selects, bit n = byte n (little-endian)
- `wb_ack_o`  out  1  one-cycle completion pulse
- `wb_dat_o`  out  32  read data, valid with ack and held until next read completes
- `ram_addr`  out  ADDR_WIDTH  SRAM word address
- `ram_data`  inout  32  SRAM data bus
- `ram_ce_n`, `ram_oe_n`, `ram_we_n`  out  1  active-low controls
- `ram_be_n`  out  4  active-low byte enables, `~wb_sel_i`

## Operation
- States: IDLE, READ, WR_SETUP, WR_PULSE, WR_HOLD, DONE.
- IDLE: on `wb_cyc_i & wb_stb_i` capture address, data, sel, we. Read → READ, write → WR_SETUP. Otherwise stay.
- READ: ce_n=0, oe_n=0, we_n=1, be_n=~sel, data bus Z. Stay `READ_CYCLES` cycles. On the final cycle's edge latch `ram_data` into `wb_dat_o`; → DONE.
- WR_SETUP (1 cycle): ce_n=0, oe_n=1, we_n=1, bus driven with write data → WR_PULSE.
- WR_PULSE (`WRITE_CYCLES` cycles): we_n=0, rest as setup → WR_HOLD.
- WR_HOLD (1 cycle): we_n=1, ce_n=0, data still driven → DONE.
- DONE (1 cycle): `wb_ack_o`=1; ce_n=oe_n=we_n=1, be_n=4'hF, bus Z → IDLE.
- Bus contention: `ram_data` is driven only in WR_SETUP/WR_PULSE/WR_HOLD; oe_n is never low in those states. At least DONE+IDLE separate any read from the next write drive.
- `wb_sel_i`=0 on write: full cycle executed with be_n=4'hF, ack issued normally.
- Requests arriving outside IDLE are not sampled; the master holds stb until ack (Wishbone classic).
- Strobe still high in the cycle after ack is a new request, accepted in IDLE.
- Reset, also mid-operation: the next edge forces IDLE and all outputs to reset values; an aborted write leaves target memory contents undefined, no ack issued.

## Timing
- Reset values: `wb_ack_o`=0, `wb_dat_o`=0, `ram_addr`=0, ce_n=oe_n=we_n=1, be_n=4'hF, `ram_data` Z.
- Request sampled in IDLE at edge T. SRAM pins change at edge T (registered), valid from cycle T+1.
- Read ack is high in cycle T+1+READ_CYCLES; default is T+3.
- Write ack is high in cycle T+3+WRITE_CYCLES; default is T+4.
- Ack is always exactly one cycle wide.
- Back-to-back accesses with stb held: minimum issue interval is READ_CYCLES+2 for reads and WRITE_CYCLES+4 for writes.
- Address and be_n are stable from first CE-low cycle through last CE-low cycle. Write data is stable one cycle before WE falls and one cycle after WE rises.

## Test plan
- Reset: assert `reset_btn` 2 cycles with stb high → ack 0, ce_n/oe_n/we_n 1, be_n F, bus Z; no access starts until reset drops.
- Read: SRAM word 5 preloaded 0x12345678; read adr 0x14, sel F → ack at T+3, `wb_dat_o`=0x12345678, oe_n low exactly 2 cycles.
- Byte write: word 0 = 0xAABBCCDD; write adr 0x0, dat 0x00001100, sel 0010 → ack at T+4. Read back returns 0xAABB11DD.
- Back-to-back: stb held across write 0xDEADBEEF to adr 0x40, then read adr 0x40 → second ack 4 cycles after first, data 0xDEADBEEF. Monitor flags any cycle with oe_n=0 while the bus is driven.
- Address wrap: read adr 0x00400008 → `ram_addr`=2, with bits [31:22] ignored.
- Reset mid-write: assert reset during WR_PULSE → we_n high on the next edge, no ack, IDLE. A subsequent read of a different address completes normally.
